// File: rtl/hc02_gate_tester.sv
// Sequencer that walks a quad 2-input gate package through all four input
// vectors and scores every gate output against an expected truth table.
module hc02_gate_tester #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [3:0]  EXPECT_TT     = 4'b0001
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   input  logic       abort,
   output logic [3:0] A_o,
   output logic [3:0] B_o,
   input  logic [3:0] Y_i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic       first_fail_vld,
   output logic [1:0] first_fail_vec
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 32'd1);

   function automatic logic [3:0] mismatch_f(input logic [3:0] y, input logic exp_bit);
      return y ^ {4{exp_bit}};
   endfunction

   state_t     state_r;
   state_t     state_nx_s;
   logic [1:0] vec_r;
   logic [1:0] vec_nx_s;
   logic [7:0] cnt_r;
   logic [7:0] cnt_nx_s;
   logic [3:0] y_meta_r;
   logic [3:0] y_s_r;
   logic [3:0] mism_s;
   logic [3:0] fail_mask_r;
   logic [3:0] fail_mask_nx_s;
   logic       pass_r;
   logic       pass_nx_s;
   logic       ffv_r;
   logic       ffv_nx_s;
   logic [1:0] ffvec_r;
   logic [1:0] ffvec_nx_s;
   logic [3:0] a_r;
   logic [3:0] a_nx_s;
   logic [3:0] b_r;
   logic [3:0] b_nx_s;
   logic       busy_r;
   logic       busy_nx_s;
   logic       done_r;
   logic       done_nx_s;

   // Two-flop synchronizer on the asynchronous gate outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         y_meta_r <= 4'd0;
         y_s_r    <= 4'd0;
      end else begin
         y_meta_r <= Y_i;
         y_s_r    <= y_meta_r;
      end
   end

   assign mism_s = mismatch_f(y_s_r, EXPECT_TT[vec_r]);

   // Next-state, vector/counter sequencing and result accumulation
   always_comb begin
      state_nx_s     = state_r;
      vec_nx_s       = vec_r;
      cnt_nx_s       = cnt_r;
      fail_mask_nx_s = fail_mask_r;
      pass_nx_s      = pass_r;
      ffv_nx_s       = ffv_r;
      ffvec_nx_s     = ffvec_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s     = ST_SETTLE;
               vec_nx_s       = 2'd0;
               cnt_nx_s       = CNT_LOAD;
               fail_mask_nx_s = 4'd0;
               pass_nx_s      = 1'b0;
               ffv_nx_s       = 1'b0;
               ffvec_nx_s     = 2'd0;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_nx_s = ST_IDLE;
               pass_nx_s  = 1'b0;
            end else if (cnt_r == 8'd0) begin
               state_nx_s = ST_CHECK;
            end else begin
               cnt_nx_s = cnt_r - 8'd1;
            end
         end
         ST_CHECK: begin
            if (abort) begin
               // abort discards this cycle's comparison
               state_nx_s = ST_IDLE;
               pass_nx_s  = 1'b0;
            end else begin
               fail_mask_nx_s = fail_mask_r | mism_s;
               if ((mism_s != 4'd0) && !ffv_r) begin
                  ffv_nx_s   = 1'b1;
                  ffvec_nx_s = vec_r;
               end else begin
                  ffv_nx_s   = ffv_r;
               end
               if (vec_r == 2'd3) begin
                  state_nx_s = ST_DONE;
                  pass_nx_s  = ((fail_mask_r | mism_s) == 4'd0);
               end else begin
                  state_nx_s = ST_SETTLE;
                  vec_nx_s   = vec_r + 2'd1;
                  cnt_nx_s   = CNT_LOAD;
               end
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so the registered pins track the state they describe
   always_comb begin
      a_nx_s    = 4'd0;
      b_nx_s    = 4'd0;
      busy_nx_s = 1'b0;
      done_nx_s = 1'b0;
      case (state_nx_s)
         ST_SETTLE, ST_CHECK: begin
            a_nx_s    = {4{vec_nx_s[1]}};
            b_nx_s    = {4{vec_nx_s[0]}};
            busy_nx_s = 1'b1;
         end
         ST_DONE: begin
            done_nx_s = 1'b1;
         end
         ST_IDLE: begin
            busy_nx_s = 1'b0;
         end
         default: begin
            busy_nx_s = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Sequencing and result registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         vec_r       <= 2'd0;
         cnt_r       <= 8'd0;
         fail_mask_r <= 4'd0;
         pass_r      <= 1'b0;
         ffv_r       <= 1'b0;
         ffvec_r     <= 2'd0;
      end else begin
         vec_r       <= vec_nx_s;
         cnt_r       <= cnt_nx_s;
         fail_mask_r <= fail_mask_nx_s;
         pass_r      <= pass_nx_s;
         ffv_r       <= ffv_nx_s;
         ffvec_r     <= ffvec_nx_s;
      end
   end

   // Pin output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_r    <= 4'd0;
         b_r    <= 4'd0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         a_r    <= a_nx_s;
         b_r    <= b_nx_s;
         busy_r <= busy_nx_s;
         done_r <= done_nx_s;
      end
   end

   assign A_o            = a_r;
   assign B_o            = b_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign pass           = pass_r;
   assign fail_mask      = fail_mask_r;
   assign first_fail_vld = ffv_r;
   assign first_fail_vec = ffvec_r;

endmodule
